// File: rtl/instr_split_queue_pkg.sv
// ---------------------------------------------------------------------------
// instr_split_queue_pkg : shared instruction-field constants and queue state.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package instr_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SA_MSB     = 10;
  localparam int SA_LSB     = 6;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int IMM16_MSB  = 15;
  localparam int IMM16_LSB  = 0;
  localparam int IMM26_MSB  = 25;
  localparam int IMM26_LSB  = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_split_queue_if.sv
// ---------------------------------------------------------------------------
// instr_split_queue_if : IF->ID queue handshake bus (optional IQ_IMM_EXT_EN).
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_split_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  import instr_pkg::*;

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [INSTR_W-1:0]       in_instr;
  logic [PC_W-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [INSTR_W-1:0]       out_instr;
  logic [PC_W-1:0]          out_pc;
  logic [5:0]               opcode;
  logic [4:0]               rs;
  logic [4:0]               rt;
  logic [4:0]               rd;
  logic [4:0]               sa;
  logic [5:0]               func;
  logic [15:0]              imm16;
  logic [25:0]              imm26;
  logic [$clog2(DEPTH):0]   count;
`ifdef IQ_IMM_EXT_EN
  logic [31:0]              imm_sext;
  logic [31:0]              imm_zext;
  logic [31:0]              imm_lui;
`endif

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output opcode, rs, rt, rd, sa, func, imm16, imm26,
`ifdef IQ_IMM_EXT_EN
    output imm_sext, imm_zext, imm_lui,
`endif
    output count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  opcode, rs, rt, rd, sa, func, imm16, imm26,
`ifdef IQ_IMM_EXT_EN
    input  imm_sext, imm_zext, imm_lui,
`endif
    input  count
  );

endinterface

`default_nettype wire

// File: rtl/instr_split_queue_fields.sv
// ---------------------------------------------------------------------------
// instr_fields : combinational MIPS field slicer, extenders under IQ_IMM_EXT_EN.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fields
  import instr_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [5:0]         opcode_o,
  output logic [4:0]         rs_o,
  output logic [4:0]         rt_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         sa_o,
  output logic [5:0]         func_o,
  output logic [15:0]        imm16_o,
`ifdef IQ_IMM_EXT_EN
  output logic [31:0]        imm_sext_o,
  output logic [31:0]        imm_zext_o,
  output logic [31:0]        imm_lui_o,
`endif
  output logic [25:0]        imm26_o
);

  assign opcode_o = instr_i[OPCODE_MSB:OPCODE_LSB];
  assign rs_o     = instr_i[RS_MSB:RS_LSB];
  assign rt_o     = instr_i[RT_MSB:RT_LSB];
  assign rd_o     = instr_i[RD_MSB:RD_LSB];
  assign sa_o     = instr_i[SA_MSB:SA_LSB];
  assign func_o   = instr_i[FUNC_MSB:FUNC_LSB];
  assign imm16_o  = instr_i[IMM16_MSB:IMM16_LSB];
  assign imm26_o  = instr_i[IMM26_MSB:IMM26_LSB];

`ifdef IQ_IMM_EXT_EN
  assign imm_sext_o = {{16{instr_i[IMM16_MSB]}}, instr_i[IMM16_MSB:IMM16_LSB]};
  assign imm_zext_o = {16'h0, instr_i[IMM16_MSB:IMM16_LSB]};
  assign imm_lui_o  = {instr_i[IMM16_MSB:IMM16_LSB], 16'h0};
`endif

endmodule

`default_nettype wire

// File: rtl/instr_split_queue.sv
// ---------------------------------------------------------------------------
// instr_split_queue : FWFT IF->ID instruction queue with flush and head decode.
// Optional feature macro: IQ_IMM_EXT_EN.  Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_split_queue
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_split_queue_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic [PTR_W-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]   count_q, count_d;
  occ_state_e         state_q, state_d;

  logic               push, pop;
  logic [INSTR_W-1:0] head_instr;

  assign bus.in_ready  = (state_q != OCC_FULL);
  assign bus.out_valid = (state_q != OCC_EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    state_d = state_q;
    if (bus.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      state_d = OCC_EMPTY;
    end else begin
      case ({push, pop})
        2'b10: begin
          wp_d    = wp_q + PTR_W'(1);
          count_d = count_q + CNT_W'(1);
          state_d = (count_q == CNT_W'(DEPTH - 1)) ? OCC_FULL : OCC_PARTIAL;
        end
        2'b01: begin
          rp_d    = rp_q + PTR_W'(1);
          count_d = count_q - CNT_W'(1);
          state_d = (count_q == CNT_W'(1)) ? OCC_EMPTY : OCC_PARTIAL;
        end
        2'b11: begin
          wp_d = wp_q + PTR_W'(1);
          rp_d = rp_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      state_q <= OCC_EMPTY;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Storage is deliberately left unreset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (reset && !bus.flush && push) begin
      instr_mem_q[wp_q] <= bus.in_instr;
      pc_mem_q[wp_q]    <= bus.in_pc;
    end
  end

  assign head_instr    = bus.out_valid ? instr_mem_q[rp_q] : NOP_INSTR;
  assign bus.out_instr = head_instr;
  assign bus.out_pc    = bus.out_valid ? pc_mem_q[rp_q] : '0;
  assign bus.count     = count_q;

  instr_fields u_fields (
    .instr_i    (head_instr),
    .opcode_o   (bus.opcode),
    .rs_o       (bus.rs),
    .rt_o       (bus.rt),
    .rd_o       (bus.rd),
    .sa_o       (bus.sa),
    .func_o     (bus.func),
    .imm16_o    (bus.imm16),
`ifdef IQ_IMM_EXT_EN
    .imm_sext_o (bus.imm_sext),
    .imm_zext_o (bus.imm_zext),
    .imm_lui_o  (bus.imm_lui),
`endif
    .imm26_o    (bus.imm26)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_split_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_split_queue : directed scoreboard bench for instr_split_queue.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_split_queue;
  import instr_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_split_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  instr_split_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          exp_count = 0;
  logic [63:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; checks head against scoreboard, then count after the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic        do_push, do_pop;
    logic [63:0] head;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
    check("in_ready", 64'(bus.in_ready), 64'(exp_count < DEPTH));
    check("out_valid", 64'(bus.out_valid), 64'(exp_count > 0));
    if (exp_count > 0) begin
      head = sb[0];
      check("out_instr", 64'(bus.out_instr), 64'(head[31:0]));
      check("out_pc", 64'(bus.out_pc), 64'(head[63:32]));
    end else begin
      check("empty_instr", 64'(bus.out_instr), 64'h0);
      check("empty_pc", 64'(bus.out_pc), 64'h0);
    end
    do_push = v && (exp_count < DEPTH) && !fl;
    do_pop  = rdy && (exp_count > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      sb.delete();
      exp_count = 0;
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
        exp_count--;
      end
      if (do_push) begin
        sb.push_back({pc, ins});
        exp_count++;
      end
    end
    #1;
    check("count", 64'(bus.count), 64'(exp_count));
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hDEAD_BEEF;
    bus.in_pc    = 32'h0000_1234;
    bus.out_ready = 1'b1;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    exp_count = 0;
    check("rst_count", 64'(bus.count), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);
    check("rst_out_instr", 64'(bus.out_instr), 64'h0);
    check("rst_out_pc", 64'(bus.out_pc), 64'h0);
    check("rst_fields", 64'({bus.opcode, bus.rs, bus.rt, bus.rd, bus.sa, bus.func}), 64'h0);
    check("rst_imm", 64'({bus.imm16, bus.imm26}), 64'h0);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();

    // Fill two, then drain with field checks on each head.
    cycle(1'b1, 32'h8C88_0004, 32'h3000, 1'b0, 1'b0);
    cycle(1'b1, 32'h0109_5020, 32'h3004, 1'b0, 1'b0);
    check("fill_count2", 64'(bus.count), 64'd2);
    check("opcode", 64'(bus.opcode), 64'h23);
    check("rs", 64'(bus.rs), 64'd4);
    check("rt", 64'(bus.rt), 64'd8);
    check("imm16", 64'(bus.imm16), 64'h0004);
    check("imm26", 64'(bus.imm26), 64'h088_0004);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("rd", 64'(bus.rd), 64'd10);
    check("func", 64'(bus.func), 64'h20);
    check("sa", 64'(bus.sa), 64'd0);
    check("pc2", 64'(bus.out_pc), 64'h3004);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full: extra push ignored, simultaneous pop+push rejects the push.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h1000_0000 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    check("full_in_ready", 64'(bus.in_ready), 64'h0);
    cycle(1'b1, 32'hBAD0_0001, 32'h4FFC, 1'b0, 1'b0);
    cycle(1'b1, 32'hBAD0_0002, 32'h4FF8, 1'b1, 1'b0);
    check("full_poppush_count", 64'(bus.count), 64'(DEPTH - 1));
    repeat (DEPTH - 1) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drained", 64'(bus.out_valid), 64'h0);

    // Wrap: sustained push+pop across several pointer wraps.
    cycle(1'b1, 32'hA000_0000, 32'h5000, 1'b0, 1'b0);
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      cycle(1'b1, 32'hA000_0000 + 32'(i), 32'h5000 + 32'(4 * i), 1'b1, 1'b0);
      check("wrap_count", 64'(bus.count), 64'd1);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent push and pop discards everything.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'hC000_0000 + 32'(i), 32'h7000 + 32'(4 * i), 1'b0, 1'b0);
    check("pre_flush_count", 64'(bus.count), 64'd3);
    cycle(1'b1, 32'hC0FF_EE00, 32'h7FF0, 1'b1, 1'b1);
    check("flush_count", 64'(bus.count), 64'h0);
    check("flush_out_valid", 64'(bus.out_valid), 64'h0);

    cycle(1'b1, 32'h2401_8000, 32'h6000, 1'b0, 1'b0);
    check("imm16_neg", 64'(bus.imm16), 64'h8000);
`ifdef IQ_IMM_EXT_EN
    check("imm_sext", 64'(bus.imm_sext), 64'hFFFF_8000);
    check("imm_zext", 64'(bus.imm_zext), 64'h0000_8000);
    check("imm_lui", 64'(bus.imm_lui), 64'h8000_0000);
`endif
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IQ_IMM_EXT_EN
    check("imm_sext_empty", 64'(bus.imm_sext), 64'h0);
`endif

    // Reset mid-operation loses all entries; queue works normally afterwards.
    cycle(1'b1, 32'hE000_0001, 32'h8000, 1'b0, 1'b0);
    cycle(1'b1, 32'hE000_0002, 32'h8004, 1'b0, 1'b0);
    apply_reset();
    cycle(1'b1, 32'hF000_0001, 32'h9000, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
